packet_injector: RTL and testbench
==================================

Name: packet_injector

Overview:
Upstream source stage for the 1x3 router. It buffers a host-written payload, then on command emits one complete router packet on the router input port: header byte, payload bytes, parity byte. It drives the router's packet-valid and data inputs and obeys the router's busy signal. A packet is only launched once its whole payload is buffered, so o_Valid_Packet never has a bubble mid-packet.

Parameters:
BUF_DEPTH, 64, payload buffer depth in bytes (power of 2, at least 64 so a max-length packet of 63 bytes fits)
GAP_CYCLES, 2, idle cycles forced after each packet before the next start is accepted (minimum 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
i_Wr_En  in  1  host payload write strobe
i_Wr_Data  in  8  host payload byte
i_Start  in  1  launch request, sampled only when o_Start_Ready=1
i_Dest_Addr  in  2  destination port 0..2; 3 is illegal
i_Length  in  6  payload length 0..63
i_Sig_Busy  in  1  router busy; byte not accepted while high
o_Valid_Packet  out  1  to router packet-valid input
o_Data  out  8  to router data input
o_Start_Ready  out  1  high in IDLE
o_Buf_Count  out  7  bytes currently buffered
o_Buf_Full  out  1  buffer full
o_Done  out  1  1-cycle pulse, packet complete
o_Error  out  1  1-cycle pulse, start rejected
o_Overflow  out  1  sticky; write attempted while full

Behaviour:
- Reset values: state IDLE, buffer empty, o_Valid_Packet=0, o_Data=0, o_Start_Ready=1, o_Buf_Count=0, o_Buf_Full=0, o_Done=0, o_Error=0, o_Overflow=0, parity accumulator=0.
- Reset mid-packet: on the next edge, return to IDLE, flush the buffer, drop o_Valid_Packet. No parity byte is sent.
- Buffer: synchronous FIFO, first-word-fall-through internally.
  - A write with i_Wr_En=1 and not full pushes i_Wr_Data.
  - A write while full is dropped and sets o_Overflow, which holds until reset.
  - Write and pop in the same cycle are both honoured; count is unchanged.
  - A write is accepted in any state.
- Header format: {i_Length[5:0], i_Dest_Addr[1:0]}.
- Parity: XOR of header and all payload bytes.
- Accept rule: the router takes the byte on o_Data at an edge where state is HEADER, PAYLOAD or PARITY and i_Sig_Busy=0.
  - While i_Sig_Busy=1, o_Data, o_Valid_Packet and the state hold.
- FSM states: IDLE, HEADER, PAYLOAD, PARITY, GAP.
  - IDLE: o_Valid_Packet=0.
    - i_Start=1 with i_Dest_Addr=3, or o_Buf_Count<i_Length: pulse o_Error for 1 cycle, stay IDLE.
    - Otherwise latch length, go to HEADER, register o_Data=header, o_Valid_Packet=1, parity=header. The header appears on the cycle after i_Start.
  - HEADER: on accept:
    - length>0: go to PAYLOAD, o_Data=buffer head, pop, parity^=byte.
    - length=0: go to PARITY.
  - PAYLOAD: o_Valid_Packet=1; down-counter of remaining bytes. On accept of the last payload byte, go to PARITY, o_Data=parity, o_Valid_Packet=0. Otherwise load the next head and pop.
  - PARITY: o_Valid_Packet=0, o_Data=parity. On accept, go to GAP.
  - GAP: o_Done=1 on the first GAP cycle only; o_Data=0; after GAP_CYCLES cycles, go to IDLE.
- o_Start_Ready=1 only in IDLE.
- Length is latched at start; later changes to i_Length or i_Dest_Addr have no effect on the packet in flight.
- Buffered bytes beyond the latched length stay queued for the next packet.

Test Plan:
- Write A5,3C,FF; start addr=1 len=3, busy=0 -> o_Data sequence 0x0D,A5,3C,FF (valid=1), then 0x6B (valid=0); o_Done pulse; buffer count 0; o_Start_Ready returns after 2 gap cycles.
- Empty buffer; start addr=2 len=0 -> header 0x02 with valid=1, then parity 0x02 with valid=0; o_Done pulse.
- Start with addr=3, or len=4 with only 3 bytes buffered -> o_Error 1-cycle pulse; o_Valid_Packet stays 0; count unchanged.
- Hold i_Sig_Busy=1 for 3 cycles during the header and 2 cycles mid-payload -> o_Data and valid held; byte order and parity identical to scenario 1.
- Fill 64 bytes, write a 65th -> dropped, o_Overflow=1 until reset; write concurrently during a send -> count is consistent.
- Assert reset during PAYLOAD -> next cycle valid=0, count=0, o_Start_Ready=1; no parity byte emitted.

Source files
------------

// File: rtl/packet_injector.sv
// Router source stage: buffers a host payload and emits one
// header/payload/parity packet per accepted start request.
module packet_injector #(
    parameter int BUF_DEPTH  = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_Wr_En,
    input  logic [7:0] i_Wr_Data,
    input  logic       i_Start,
    input  logic [1:0] i_Dest_Addr,
    input  logic [5:0] i_Length,
    input  logic       i_Sig_Busy,
    output logic       o_Valid_Packet,
    output logic [7:0] o_Data,
    output logic       o_Start_Ready,
    output logic [6:0] o_Buf_Count,
    output logic       o_Buf_Full,
    output logic       o_Done,
    output logic       o_Error,
    output logic       o_Overflow
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    logic [7:0]    mem_q [BUF_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    par_q, par_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic [5:0]    rem_q, rem_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          full, push, pop, accept;
    logic [7:0]    head, hdr;

    assign full   = (count_q == CW'(BUF_DEPTH));
    assign push   = i_Wr_En && !full;
    assign head   = mem_q[rd_ptr_q];
    assign hdr    = {i_Length, i_Dest_Addr};
    assign accept = !i_Sig_Busy;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        par_d   = par_q;
        valid_d = valid_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pop     = 1'b0;
        ovf_d   = ovf_q | (i_Wr_En & full);
        unique case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (i_Start) begin
                    if (i_Dest_Addr == 2'd3 || count_q < CW'(i_Length)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_HEADER;
                        data_d  = hdr;
                        par_d   = hdr;
                        valid_d = 1'b1;
                        rem_d   = i_Length;
                    end
                end
            end
            // rem_q counts payload bytes not yet placed on o_Data
            S_HEADER, S_PAYLOAD: begin
                if (accept) begin
                    if (rem_q != 6'd0) begin
                        state_d = S_PAYLOAD;
                        data_d  = head;
                        par_d   = par_q ^ head;
                        pop     = 1'b1;
                        rem_d   = rem_q - 6'd1;
                    end else begin
                        state_d = S_PARITY;
                        data_d  = par_q;
                        valid_d = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (accept) begin
                    state_d = S_GAP;
                    data_d  = 8'd0;
                    done_d  = 1'b1;
                    gap_d   = '0;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_Wr_Data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= 8'd0;
            par_q    <= 8'd0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            rem_q    <= 6'd0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_d;
            data_q   <= data_d;
            par_q    <= par_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            rem_q    <= rem_d;
            gap_q    <= gap_d;
        end
    end

    assign o_Valid_Packet = valid_q;
    assign o_Data         = data_q;
    assign o_Start_Ready  = (state_q == S_IDLE);
    assign o_Buf_Count    = 7'(count_q);
    assign o_Buf_Full     = full;
    assign o_Done         = done_q;
    assign o_Error        = err_q;
    assign o_Overflow     = ovf_q;

endmodule

// File: tb/tb_packet_injector.sv
// Directed bench for packet_injector: packet framing, busy stalls,
// start rejection, buffer overflow and mid-packet reset.
module tb_packet_injector;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_Wr_En;
    logic [7:0] i_Wr_Data;
    logic       i_Start;
    logic [1:0] i_Dest_Addr;
    logic [5:0] i_Length;
    logic       i_Sig_Busy;
    logic       o_Valid_Packet;
    logic [7:0] o_Data;
    logic       o_Start_Ready;
    logic [6:0] o_Buf_Count;
    logic       o_Buf_Full;
    logic       o_Done;
    logic       o_Error;
    logic       o_Overflow;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] pl [64];

    packet_injector #(.BUF_DEPTH(64), .GAP_CYCLES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_Wr_En        (i_Wr_En),
        .i_Wr_Data      (i_Wr_Data),
        .i_Start        (i_Start),
        .i_Dest_Addr    (i_Dest_Addr),
        .i_Length       (i_Length),
        .i_Sig_Busy     (i_Sig_Busy),
        .o_Valid_Packet (o_Valid_Packet),
        .o_Data         (o_Data),
        .o_Start_Ready  (o_Start_Ready),
        .o_Buf_Count    (o_Buf_Count),
        .o_Buf_Full     (o_Buf_Full),
        .o_Done         (o_Done),
        .o_Error        (o_Error),
        .o_Overflow     (o_Overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        i_Wr_En   = 1'b1;
        i_Wr_Data = d;
        tick();
        i_Wr_En   = 1'b0;
    endtask

    // Sends pl[0..len-1]; hb busy cycles on the header, pn busy cycles
    // while payload byte pi is presented.
    task automatic send(input logic [1:0] a, input int len, input int hb,
                        input int pi, input int pn);
        logic [7:0] hdr;
        logic [7:0] par;
        i_Start     = 1'b1;
        i_Dest_Addr = a;
        i_Length    = len[5:0];
        tick();
        i_Start     = 1'b0;
        i_Dest_Addr = 2'd3;
        i_Length    = 6'd63;
        hdr = {len[5:0], a};
        par = hdr;
        chk("hdr", o_Data, hdr);
        chk("hdr_vld", o_Valid_Packet, 1);
        chk("hdr_rdy", o_Start_Ready, 0);
        for (int k = 0; k < hb; k++) begin
            i_Sig_Busy = 1'b1;
            tick();
            chk("hdr_hold", o_Data, hdr);
            chk("hdr_hold_vld", o_Valid_Packet, 1);
        end
        i_Sig_Busy = 1'b0;
        for (int i = 0; i < len; i++) begin
            tick();
            chk("pl", o_Data, pl[i]);
            chk("pl_vld", o_Valid_Packet, 1);
            par = par ^ pl[i];
            if (i == pi) begin
                for (int k = 0; k < pn; k++) begin
                    i_Sig_Busy = 1'b1;
                    tick();
                    chk("pl_hold", o_Data, pl[i]);
                    chk("pl_hold_vld", o_Valid_Packet, 1);
                end
                i_Sig_Busy = 1'b0;
            end
        end
        tick();
        chk("par", o_Data, par);
        chk("par_vld", o_Valid_Packet, 0);
        tick();
        chk("done", o_Done, 1);
        chk("gap_data", o_Data, 0);
        chk("gap_rdy", o_Start_Ready, 0);
        tick();
        chk("done_pulse", o_Done, 0);
        chk("gap2_rdy", o_Start_Ready, 0);
        tick();
        chk("rdy_back", o_Start_Ready, 1);
    endtask

    initial begin
        reset       = 1'b1;
        i_Wr_En     = 1'b0;
        i_Wr_Data   = 8'd0;
        i_Start     = 1'b0;
        i_Dest_Addr = 2'd0;
        i_Length    = 6'd0;
        i_Sig_Busy  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_vld", o_Valid_Packet, 0);
        chk("rst_data", o_Data, 0);
        chk("rst_rdy", o_Start_Ready, 1);
        chk("rst_cnt", o_Buf_Count, 0);
        chk("rst_full", o_Buf_Full, 0);
        chk("rst_done", o_Done, 0);
        chk("rst_err", o_Error, 0);
        chk("rst_ovf", o_Overflow, 0);

        // basic packet: 0D A5 3C FF, parity 6B
        wr(8'hA5); wr(8'h3C); wr(8'hFF);
        chk("cnt3", o_Buf_Count, 3);
        pl[0] = 8'hA5; pl[1] = 8'h3C; pl[2] = 8'hFF;
        send(2'd1, 3, 0, -1, 0);
        chk("cnt_after", o_Buf_Count, 0);

        // zero-length packet
        send(2'd2, 0, 0, -1, 0);

        // rejected starts
        i_Start = 1'b1; i_Dest_Addr = 2'd3; i_Length = 6'd0;
        tick();
        i_Start = 1'b0;
        chk("err_addr", o_Error, 1);
        chk("err_addr_vld", o_Valid_Packet, 0);
        chk("err_addr_rdy", o_Start_Ready, 1);
        tick();
        chk("err_pulse", o_Error, 0);
        wr(8'h11); wr(8'h22); wr(8'h33);
        i_Start = 1'b1; i_Dest_Addr = 2'd0; i_Length = 6'd4;
        tick();
        i_Start = 1'b0;
        chk("err_len", o_Error, 1);
        chk("err_len_vld", o_Valid_Packet, 0);
        chk("err_len_cnt", o_Buf_Count, 3);
        tick();
        chk("err_len_pulse", o_Error, 0);
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send(2'd0, 3, 0, -1, 0);

        // busy stalls on header and mid-payload
        wr(8'hA5); wr(8'h3C); wr(8'hFF);
        pl[0] = 8'hA5; pl[1] = 8'h3C; pl[2] = 8'hFF;
        send(2'd1, 3, 3, 1, 2);
        chk("busy_cnt", o_Buf_Count, 0);

        // overflow
        for (int i = 0; i < 64; i++) wr(8'(i));
        chk("fill_cnt", o_Buf_Count, 64);
        chk("fill_full", o_Buf_Full, 1);
        chk("fill_ovf0", o_Overflow, 0);
        wr(8'hEE);
        chk("ovf_cnt", o_Buf_Count, 64);
        chk("ovf_set", o_Overflow, 1);
        tick();
        chk("ovf_sticky", o_Overflow, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ovf_clr", o_Overflow, 0);
        chk("ovf_rst_cnt", o_Buf_Count, 0);

        // writes during a send: 3 + 8 pushes - 3 pops
        wr(8'h01); wr(8'h02); wr(8'h03);
        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
        i_Wr_En = 1'b1; i_Wr_Data = 8'h5A;
        send(2'd2, 3, 0, -1, 0);
        i_Wr_En = 1'b0;
        chk("conc_cnt", o_Buf_Count, 8);

        // reset mid-payload
        i_Start = 1'b1; i_Dest_Addr = 2'd2; i_Length = 6'd8;
        tick();
        i_Start = 1'b0;
        tick();
        tick();
        chk("mid_data", o_Data, 8'h5A);
        chk("mid_vld", o_Valid_Packet, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_vld", o_Valid_Packet, 0);
        chk("mrst_cnt", o_Buf_Count, 0);
        chk("mrst_rdy", o_Start_Ready, 1);
        chk("mrst_data", o_Data, 0);
        tick();
        chk("mrst_nopar", o_Data, 0);
        chk("mrst_vld2", o_Valid_Packet, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
